mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter and burst sequencer that shares the single main-memory port between the data cache (D side, behind the write-back stage) and the instruction cache (I side). It serves one whole cache line per grant, one word at a time, and paces each word by a fixed memory latency. It streams read words back to the owning cache and feeds write-back words from it. It also keeps grant and conflict counters for the cache hit/miss statistics.

## Interface

- LINE_ADDR_LEN, 3: log2 of words per line; a burst is 2^LINE_ADDR_LEN words.
- ADDR_LEN, 13: width of the line address (tag + set bits).
- MEM_LAT, 4: cycles each word's address is held before data or write completes; must be ≥1.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- d_req / i_req  in  1  line-transfer request; held until done is seen.
- d_we / i_we  in  1  1 = write-back line, 0 = refill read; sampled at grant.
- d_line / i_line  in  ADDR_LEN  line address; sampled at grant.
- d_wdata / i_wdata  in  32  write word selected by d_idx / i_idx, combinational from the cache.
- d_idx / i_idx  out  LINE_ADDR_LEN  current word index while owner; 0 otherwise.
- d_rvalid / i_rvalid  out  1  read word valid this cycle.
- d_rdata / i_rdata  out  32  read word (mem_rdata passthrough); 0 when not rvalid.
- d_done / i_done  out  1  one-cycle pulse: burst finished.
- mem_addr  out  ADDR_LEN+LINE_ADDR_LEN  word address {line, idx}.
- mem_we  out  1  write strobe; one cycle per word.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  valid in the MEM_LAT-th cycle mem_addr is held stable.
- busy  out  1  state ≠ IDLE.
- owner  out  1  0 = D, 1 = I; meaningful only when busy.
- d_grant_cnt, i_grant_cnt, conflict_cnt  out  32  statistics counters.

## Operation

- States:
  - IDLE: no transfer in progress.
  - XFER: a line burst is in progress.
  - DONE: burst finished; done pulse cycle.
- IDLE → XFER when any request is high.
  - Only one request high: that side wins.
  - Both high: the side opposite `last` wins. `last` is the most recently served side; its reset value is I, so D wins the first tie.
  - At grant, latch owner, the owner's line address and we; set idx = 0 and lat = 0.
  - Increment the winner's grant counter.
  - If both requests were high, increment conflict_cnt.
- XFER:
  - mem_addr = {line_latched, idx}.
  - lat counts 0..MEM_LAT-1.
  - Word completion happens in the cycle with lat == MEM_LAT-1:
    - Read: owner's rvalid = 1 and rdata = mem_rdata.
    - Write: mem_we = 1 and mem_wdata = owner's wdata.
  - In all other XFER cycles, mem_we = 0 and mem_wdata = 0.
  - After each completion, lat returns to 0 and idx increments.
  - When idx == 2^LINE_ADDR_LEN-1 completes, go to DONE.
- DONE:
  - Owner's done = 1 for exactly this cycle.
  - last ← owner.
  - Requests are ignored; next state is IDLE.
- Request deassertion during XFER is ignored; the burst always completes.
- The non-owner's outputs stay 0 throughout.
- Counters wrap modulo 2^32.

## Timing

- Reset values: state IDLE, last = I, busy = 0, owner = 0, all idx/rvalid/rdata/done = 0, mem_* = 0, all counters = 0.
- Grant latency: a request seen in an IDLE cycle at edge k puts the block in XFER from cycle k+1.
- Word n completes in cycle k+1+n·MEM_LAT+(MEM_LAT-1).
- Done is at cycle k+1+2^LINE_ADDR_LEN·MEM_LAT.
- The earliest next grant is decided in the IDLE cycle after done.
- Line service time is 2^LINE_ADDR_LEN·MEM_LAT + 2 cycles, IDLE included. With defaults this is 34.
- A request arriving during XFER/DONE waits. It is evaluated in the next IDLE cycle against the updated `last`.
- rst during XFER: return to IDLE next edge. The partial burst is abandoned and no done is issued; counters and last are reset.
- A simultaneous rst and request: rst wins.
- MEM_LAT = 1: every XFER cycle completes a word.

## Test plan

- Single D read, defaults, mem_rdata = 0x1000+word address, line 0x005: d_rvalid on 8 cycles spaced 4 apart, d_idx 0..7, data 0x1028..0x102F, d_done 33 cycles after grant; i_* stay 0.
- Both requests high from reset: D served first, then I (grant in IDLE after D done); conflict_cnt = 1, d_grant_cnt = i_grant_cnt = 1.
- D requests a second line immediately while I waits: I is served before the second D line (round-robin).
- I write-back of 8 words: mem_we pulses exactly 8 times, every 4th cycle. mem_addr = {line, idx} with mem_wdata equal to i_wdata for that idx; no rvalid.
- rst asserted in the 3rd word of a D read: next cycle busy = 0, no d_done, counters 0. A new D request then restarts at idx 0.
- MEM_LAT = 1 read: 8 consecutive rvalid cycles, done 9 cycles after grant.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the D-cache, I-cache and main-memory signals around mem_arbiter.
// The arbiter takes the slave view; caches, memory and benches take the master view.
interface mem_arbiter_if #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 13
);
    logic                              d_req;
    logic                              i_req;
    logic                              d_we;
    logic                              i_we;
    logic [ADDR_LEN-1:0]               d_line;
    logic [ADDR_LEN-1:0]               i_line;
    logic [31:0]                       d_wdata;
    logic [31:0]                       i_wdata;
    logic [LINE_ADDR_LEN-1:0]          d_idx;
    logic [LINE_ADDR_LEN-1:0]          i_idx;
    logic                              d_rvalid;
    logic                              i_rvalid;
    logic [31:0]                       d_rdata;
    logic [31:0]                       i_rdata;
    logic                              d_done;
    logic                              i_done;
    logic [ADDR_LEN+LINE_ADDR_LEN-1:0] mem_addr;
    logic                              mem_we;
    logic [31:0]                       mem_wdata;
    logic [31:0]                       mem_rdata;
    logic                              busy;
    logic                              owner;
    logic [31:0]                       d_grant_cnt;
    logic [31:0]                       i_grant_cnt;
    logic [31:0]                       conflict_cnt;

    modport slave (
        input  d_req, i_req, d_we, i_we, d_line, i_line, d_wdata, i_wdata, mem_rdata,
        output d_idx, i_idx, d_rvalid, i_rvalid, d_rdata, i_rdata, d_done, i_done,
        output mem_addr, mem_we, mem_wdata, busy, owner,
        output d_grant_cnt, i_grant_cnt, conflict_cnt
    );

    modport master (
        output d_req, i_req, d_we, i_we, d_line, i_line, d_wdata, i_wdata, mem_rdata,
        input  d_idx, i_idx, d_rvalid, i_rvalid, d_rdata, i_rdata, d_done, i_done,
        input  mem_addr, mem_we, mem_wdata, busy, owner,
        input  d_grant_cnt, i_grant_cnt, conflict_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between D and I caches; serves a whole
// line per grant, one word every MEM_LAT cycles, and keeps grant/conflict statistics.
module mem_arbiter #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 13,
    parameter int MEM_LAT       = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int               LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                   r_state;
    logic                     r_owner;
    logic                     r_last;
    logic                     r_we;
    logic [ADDR_LEN-1:0]      r_line;
    logic [LINE_ADDR_LEN-1:0] r_idx;
    logic [LAT_W-1:0]         r_lat;
    logic [31:0]              r_d_grant_cnt;
    logic [31:0]              r_i_grant_cnt;
    logic [31:0]              r_conflict_cnt;

    logic w_xfer;
    logic w_word_done;
    logic w_rd;
    logic w_wr;
    logic w_win_i;
    logic w_both;

    // On a tie the side that was not served last wins.
    assign w_both      = bus.d_req & bus.i_req;
    assign w_win_i     = bus.i_req & (~bus.d_req | ~r_last);
    assign w_xfer      = (r_state == XFER);
    assign w_word_done = w_xfer && (r_lat == LAT_LAST);
    assign w_rd        = w_word_done & ~r_we;
    assign w_wr        = w_word_done & r_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_owner        <= 1'b0;
            r_last         <= 1'b1;
            r_we           <= 1'b0;
            r_line         <= '0;
            r_idx          <= '0;
            r_lat          <= '0;
            r_d_grant_cnt  <= 32'd0;
            r_i_grant_cnt  <= 32'd0;
            r_conflict_cnt <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.d_req || bus.i_req) begin
                        r_state <= XFER;
                        r_owner <= w_win_i;
                        r_line  <= w_win_i ? bus.i_line : bus.d_line;
                        r_we    <= w_win_i ? bus.i_we : bus.d_we;
                        r_idx   <= '0;
                        r_lat   <= '0;
                        if (w_win_i) r_i_grant_cnt <= r_i_grant_cnt + 32'd1;
                        else         r_d_grant_cnt <= r_d_grant_cnt + 32'd1;
                        if (w_both)  r_conflict_cnt <= r_conflict_cnt + 32'd1;
                    end
                end
                XFER: begin
                    if (w_word_done) begin
                        r_lat <= '0;
                        r_idx <= r_idx + LINE_ADDR_LEN'(1);
                        if (r_idx == '1) r_state <= DONE;
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                DONE: begin
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from state; the non-owner side is held at zero.
    assign bus.d_idx     = (w_xfer && !r_owner) ? r_idx : '0;
    assign bus.i_idx     = (w_xfer &&  r_owner) ? r_idx : '0;
    assign bus.d_rvalid  = w_rd & ~r_owner;
    assign bus.i_rvalid  = w_rd &  r_owner;
    assign bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : 32'd0;
    assign bus.i_rdata   = bus.i_rvalid ? bus.mem_rdata : 32'd0;
    assign bus.d_done    = (r_state == DONE) & ~r_owner;
    assign bus.i_done    = (r_state == DONE) &  r_owner;
    assign bus.mem_addr  = w_xfer ? {r_line, r_idx} : '0;
    assign bus.mem_we    = w_wr;
    assign bus.mem_wdata = w_wr ? (r_owner ? bus.i_wdata : bus.d_wdata) : 32'd0;
    assign bus.busy      = (r_state != IDLE);
    assign bus.owner     = r_owner;

    assign bus.d_grant_cnt  = r_d_grant_cnt;
    assign bus.i_grant_cnt  = r_i_grant_cnt;
    assign bus.conflict_cnt = r_conflict_cnt;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one default-latency instance and one MEM_LAT=1 instance,
// with memory returning 0x1000 + word address and caches supplying wdata from idx.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.LINE_ADDR_LEN(3), .ADDR_LEN(13)) bus ();
    mem_arbiter_if #(.LINE_ADDR_LEN(3), .ADDR_LEN(13)) bus1 ();

    mem_arbiter #(.LINE_ADDR_LEN(3), .ADDR_LEN(13), .MEM_LAT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_arbiter #(.LINE_ADDR_LEN(3), .ADDR_LEN(13), .MEM_LAT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus.mem_rdata  = 32'h1000 + 32'(bus.mem_addr);
    assign bus.d_wdata    = 32'hD000_0000 + 32'(bus.d_idx);
    assign bus.i_wdata    = 32'hCAFE_0000 + 32'(bus.i_idx);
    assign bus1.mem_rdata = 32'h1000 + 32'(bus1.mem_addr);
    assign bus1.d_wdata   = 32'd0;
    assign bus1.i_wdata   = 32'd0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.d_req = 0;  bus.i_req = 0;  bus.d_we = 0;  bus.i_we = 0;
        bus.d_line = '0; bus.i_line = '0;
        bus1.d_req = 0; bus1.i_req = 0; bus1.d_we = 0; bus1.i_we = 0;
        bus1.d_line = '0; bus1.i_line = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        rst = 1'b1;
        bus.d_req = 1'b1;
        tick;
        tests++;
        if ({bus.busy, bus.owner, bus.mem_we, bus.d_done, bus.i_done, bus.d_rvalid, bus.i_rvalid} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus.busy, bus.owner, bus.mem_we, bus.d_done, bus.i_done, bus.d_rvalid, bus.i_rvalid});
        end
        tests++;
        if ({bus.d_grant_cnt, bus.i_grant_cnt, bus.conflict_cnt} !== 96'd0) begin
            fails++;
            $display("FAIL reset_cnt: got %h %h %h expected 0", bus.d_grant_cnt, bus.i_grant_cnt, bus.conflict_cnt);
        end
        tests++;
        if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 32'h0 || bus.d_idx !== 3'd0) begin
            fails++;
            $display("FAIL reset_bus: addr %h wdata %h idx %0d expected 0", bus.mem_addr, bus.mem_wdata, bus.d_idx);
        end
        bus.d_req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        int e_idx, e_addr, e_rd;
        logic e_rv, e_done;
        do_reset;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_line = 13'h005;
        for (int c = 1; c <= 33; c++) begin
            tick;
            e_idx  = (c <= 32) ? (c - 1) / 4 : 0;
            e_rv   = (c <= 32) && ((c - 1) % 4 == 3);
            e_addr = (c <= 32) ? 32'h28 + e_idx : 0;
            e_rd   = e_rv ? 32'h1000 + e_addr : 0;
            e_done = (c == 33);
            tests++;
            if (bus.d_rvalid !== e_rv || bus.d_done !== e_done || bus.d_idx !== 3'(e_idx) ||
                bus.d_rdata !== 32'(e_rd) || bus.mem_addr !== 16'(e_addr)) begin
                fails++;
                $display("FAIL rd_cycle%0d: rv %b done %b idx %0d data %h addr %h expected %b %b %0d %h %h",
                         c, bus.d_rvalid, bus.d_done, bus.d_idx, bus.d_rdata, bus.mem_addr,
                         e_rv, e_done, e_idx, e_rd, e_addr);
            end
            tests++;
            if ({bus.i_rvalid, bus.i_done, bus.i_idx, bus.i_rdata, bus.mem_we} !== '0) begin
                fails++;
                $display("FAIL rd_iquiet%0d: i side/mem_we got %b expected 0", c,
                         {bus.i_rvalid, bus.i_done, bus.i_idx, bus.mem_we});
            end
        end
        bus.d_req = 1'b0;
        tick;
        tests++;
        if (bus.busy !== 1'b0 || bus.d_grant_cnt !== 32'd1 || bus.i_grant_cnt !== 32'd0 || bus.conflict_cnt !== 32'd0) begin
            fails++;
            $display("FAIL rd_end: busy %b dg %0d ig %0d cf %0d expected 0 1 0 0",
                     bus.busy, bus.d_grant_cnt, bus.i_grant_cnt, bus.conflict_cnt);
        end
    endtask

    task automatic test_conflict;
        int n;
        do_reset;
        bus.d_req = 1'b1; bus.i_req = 1'b1; bus.d_line = 13'h001; bus.i_line = 13'h002;
        tick;
        tests++;
        if (bus.busy !== 1'b1 || bus.owner !== 1'b0 || bus.conflict_cnt !== 32'd1 ||
            bus.d_grant_cnt !== 32'd1 || bus.i_grant_cnt !== 32'd0) begin
            fails++;
            $display("FAIL cf_first: busy %b owner %b cf %0d dg %0d ig %0d expected 1 0 1 1 0",
                     bus.busy, bus.owner, bus.conflict_cnt, bus.d_grant_cnt, bus.i_grant_cnt);
        end
        n = 1;
        while (bus.d_done !== 1'b1 && n < 40) begin tick; n++; end
        tests++;
        if (n != 33) begin
            fails++;
            $display("FAIL cf_ddone: done at cycle %0d expected 33", n);
        end
        bus.d_req = 1'b0;
        tick;
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL cf_idle: busy %b expected 0", bus.busy);
        end
        tick;
        tests++;
        if (bus.busy !== 1'b1 || bus.owner !== 1'b1 || bus.i_grant_cnt !== 32'd1 ||
            bus.d_grant_cnt !== 32'd1 || bus.conflict_cnt !== 32'd1 || bus.mem_addr !== 16'h0010) begin
            fails++;
            $display("FAIL cf_second: busy %b owner %b ig %0d dg %0d cf %0d addr %h expected 1 1 1 1 1 0010",
                     bus.busy, bus.owner, bus.i_grant_cnt, bus.d_grant_cnt, bus.conflict_cnt, bus.mem_addr);
        end
        n = 1;
        while (bus.i_done !== 1'b1 && n < 40) begin tick; n++; end
        tests++;
        if (n != 33) begin
            fails++;
            $display("FAIL cf_idone: done at cycle %0d expected 33", n);
        end
        bus.i_req = 1'b0;
        tick;
    endtask

    task automatic test_round_robin;
        int n;
        do_reset;
        bus.d_req = 1'b1; bus.d_line = 13'h010;
        tick;
        bus.i_req = 1'b1; bus.i_line = 13'h020;
        n = 1;
        while (bus.d_done !== 1'b1 && n < 40) begin tick; n++; end
        tests++;
        if (n != 33 || bus.conflict_cnt !== 32'd0) begin
            fails++;
            $display("FAIL rr_ddone: done at %0d cf %0d expected 33 0", n, bus.conflict_cnt);
        end
        bus.d_line = 13'h011;
        tick;
        tick;
        tests++;
        if (bus.owner !== 1'b1 || bus.conflict_cnt !== 32'd1 || bus.i_grant_cnt !== 32'd1 || bus.mem_addr !== 16'h0100) begin
            fails++;
            $display("FAIL rr_iwins: owner %b cf %0d ig %0d addr %h expected 1 1 1 0100",
                     bus.owner, bus.conflict_cnt, bus.i_grant_cnt, bus.mem_addr);
        end
        n = 1;
        while (bus.i_done !== 1'b1 && n < 40) begin tick; n++; end
        bus.i_req = 1'b0;
        tick;
        tick;
        tests++;
        if (bus.owner !== 1'b0 || bus.busy !== 1'b1 || bus.d_grant_cnt !== 32'd2 || bus.mem_addr !== 16'h0088) begin
            fails++;
            $display("FAIL rr_dagain: owner %b busy %b dg %0d addr %h expected 0 1 2 0088",
                     bus.owner, bus.busy, bus.d_grant_cnt, bus.mem_addr);
        end
        bus.d_req = 1'b0;
    endtask

    task automatic test_write;
        int e_idx, e_addr, pulses;
        logic e_we, e_done;
        do_reset;
        pulses = 0;
        bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_line = 13'h0AB;
        for (int c = 1; c <= 33; c++) begin
            tick;
            e_idx  = (c <= 32) ? (c - 1) / 4 : 0;
            e_we   = (c <= 32) && ((c - 1) % 4 == 3);
            e_addr = (c <= 32) ? 32'h558 + e_idx : 0;
            e_done = (c == 33);
            if (bus.mem_we === 1'b1) pulses++;
            tests++;
            if (bus.mem_we !== e_we || bus.mem_addr !== 16'(e_addr) || bus.i_done !== e_done ||
                bus.mem_wdata !== (e_we ? 32'hCAFE_0000 + 32'(e_idx) : 32'd0) ||
                bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.d_done !== 1'b0) begin
                fails++;
                $display("FAIL wr_cycle%0d: we %b addr %h wdata %h done %b rv %b%b expected we %b addr %h done %b",
                         c, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.i_done, bus.i_rvalid, bus.d_rvalid,
                         e_we, e_addr, e_done);
            end
        end
        tests++;
        if (pulses != 8) begin
            fails++;
            $display("FAIL wr_pulses: got %0d expected 8", pulses);
        end
        bus.i_req = 1'b0;
        bus.i_we = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        do_reset;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_line = 13'h003;
        for (int c = 1; c <= 10; c++) tick;
        tests++;
        if (bus.d_idx !== 3'd2) begin
            fails++;
            $display("FAIL rm_idx: got %0d expected 2", bus.d_idx);
        end
        rst = 1'b1;
        tick;
        tests++;
        if (bus.busy !== 1'b0 || bus.d_done !== 1'b0 || bus.d_idx !== 3'd0 || bus.d_grant_cnt !== 32'd0) begin
            fails++;
            $display("FAIL rm_abort: busy %b done %b idx %0d dg %0d expected 0 0 0 0",
                     bus.busy, bus.d_done, bus.d_idx, bus.d_grant_cnt);
        end
        rst = 1'b0;
        tick;
        tests++;
        if (bus.busy !== 1'b1 || bus.d_idx !== 3'd0 || bus.mem_addr !== 16'h0018 || bus.d_grant_cnt !== 32'd1) begin
            fails++;
            $display("FAIL rm_restart: busy %b idx %0d addr %h dg %0d expected 1 0 0018 1",
                     bus.busy, bus.d_idx, bus.mem_addr, bus.d_grant_cnt);
        end
        tick; tick; tick;
        tests++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h1018) begin
            fails++;
            $display("FAIL rm_word0: rv %b data %h expected 1 00001018", bus.d_rvalid, bus.d_rdata);
        end
        bus.d_req = 1'b0;
    endtask

    task automatic test_lat1;
        logic e_rv, e_done;
        int e_idx;
        do_reset;
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_line = 13'h005;
        for (int c = 1; c <= 9; c++) begin
            tick;
            e_rv   = (c <= 8);
            e_idx  = (c <= 8) ? c - 1 : 0;
            e_done = (c == 9);
            tests++;
            if (bus1.d_rvalid !== e_rv || bus1.d_done !== e_done || bus1.d_idx !== 3'(e_idx) ||
                bus1.d_rdata !== (e_rv ? 32'h1028 + 32'(e_idx) : 32'd0)) begin
                fails++;
                $display("FAIL l1_cycle%0d: rv %b done %b idx %0d data %h expected %b %b %0d",
                         c, bus1.d_rvalid, bus1.d_done, bus1.d_idx, bus1.d_rdata, e_rv, e_done, e_idx);
            end
        end
        bus1.d_req = 1'b0;
        tick;
        tests++;
        if (bus1.busy !== 1'b0 || bus1.d_grant_cnt !== 32'd1) begin
            fails++;
            $display("FAIL l1_end: busy %b dg %0d expected 0 1", bus1.busy, bus1.d_grant_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        test_reset;
        test_single_read;
        test_conflict;
        test_round_robin;
        test_write;
        test_reset_mid;
        test_lat1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
